// File: rtl/p3_bank_sequencer.sv
// Sequences one shared bank of p3to3 cells across LAYERS logical layers:
// a forward sweep, an optional backward sweep with control write-back, then a done pulse.
module p3_bank_sequencer #(
   parameter  int unsigned UNITS  = 8,
   parameter  int unsigned LAYERS = 4,
   localparam int unsigned LW     = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             start_in,
   input  logic             train_in,
   input  logic             abort_in,
   input  logic             cfg_we_in,
   input  logic [LW-1:0]    cfg_layer_in,
   input  logic [UNITS-1:0] cfg_data_in,
   output logic [UNITS-1:0] cfg_data_out,
   output logic             ready_out,
   output logic             step_out,
   output logic             dir_out,
   output logic [LW-1:0]    layer_out,
   output logic [UNITS-1:0] fcontrol_out,
   input  logic [UNITS-1:0] bcontrol_in,
   output logic             done_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FWD,
      S_BWD,
      S_DONE
   } state_t;

   localparam logic [LW-1:0] LAST_LAYER = LW'(LAYERS - 1);

   state_t           state_q;
   logic [UNITS-1:0] ctrl_q [LAYERS];
   logic             train_q;
   logic             ready_q;
   logic             step_q;
   logic             dir_q;
   logic             done_q;
   logic [LW-1:0]    layer_q;
   logic             cfg_in_range;

   assign cfg_in_range = (32'(cfg_layer_in) < LAYERS);

   always_comb begin
      cfg_data_out = '0;
      if (cfg_in_range) cfg_data_out = ctrl_q[cfg_layer_in];
   end

   // layer_q is held at 0 outside steps, so gating on step_q alone keeps fcontrol quiet.
   assign fcontrol_out = step_q ? ctrl_q[layer_q] : '0;
   assign ready_out    = ready_q;
   assign step_out     = step_q;
   assign dir_out      = dir_q;
   assign layer_out    = layer_q;
   assign done_out     = done_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         train_q <= 1'b0;
         ready_q <= 1'b1;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
         layer_q <= '0;
         for (int unsigned i = 0; i < LAYERS; i++) ctrl_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (cfg_we_in && cfg_in_range) ctrl_q[cfg_layer_in] <= cfg_data_in;
               if (start_in) begin
                  train_q <= train_in;
                  layer_q <= '0;
                  step_q  <= 1'b1;
                  dir_q   <= 1'b0;
                  ready_q <= 1'b0;
                  state_q <= S_FWD;
               end
            end

            S_FWD: begin
               if (abort_in) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  step_q  <= 1'b0;
                  dir_q   <= 1'b0;
                  layer_q <= '0;
               end else if (layer_q == LAST_LAYER) begin
                  if (train_q) begin
                     state_q <= S_BWD;
                     dir_q   <= 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     step_q  <= 1'b0;
                     layer_q <= '0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  layer_q <= layer_q + 1'b1;
               end
            end

            S_BWD: begin
               // Write-back happens even on the aborting cycle.
               ctrl_q[layer_q] <= bcontrol_in;
               if (abort_in) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  step_q  <= 1'b0;
                  dir_q   <= 1'b0;
                  layer_q <= '0;
               end else if (layer_q == '0) begin
                  state_q <= S_DONE;
                  step_q  <= 1'b0;
                  dir_q   <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  layer_q <= layer_q - 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end

            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               step_q  <= 1'b0;
               dir_q   <= 1'b0;
               layer_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_p3_bank_sequencer.sv
// Randomized bench for p3_bank_sequencer against a sweep-level reference model.
module tb_p3_bank_sequencer;

   localparam int unsigned UNITS  = 8;
   localparam int unsigned LAYERS = 4;
   localparam int unsigned LW     = 2;

   logic             clk_in       = 1'b0;
   logic             rst_n        = 1'b0;
   logic             start_in     = 1'b0;
   logic             train_in     = 1'b0;
   logic             abort_in     = 1'b0;
   logic             cfg_we_in    = 1'b0;
   logic [LW-1:0]    cfg_layer_in = '0;
   logic [UNITS-1:0] cfg_data_in  = '0;
   logic [UNITS-1:0] bcontrol_in  = '0;
   logic [UNITS-1:0] cfg_data_out;
   logic             ready_out;
   logic             step_out;
   logic             dir_out;
   logic [LW-1:0]    layer_out;
   logic [UNITS-1:0] fcontrol_out;
   logic             done_out;

   p3_bank_sequencer #(.UNITS(UNITS), .LAYERS(LAYERS)) dut (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .start_in     (start_in),
      .train_in     (train_in),
      .abort_in     (abort_in),
      .cfg_we_in    (cfg_we_in),
      .cfg_layer_in (cfg_layer_in),
      .cfg_data_in  (cfg_data_in),
      .cfg_data_out (cfg_data_out),
      .ready_out    (ready_out),
      .step_out     (step_out),
      .dir_out      (dir_out),
      .layer_out    (layer_out),
      .fcontrol_out (fcontrol_out),
      .bcontrol_in  (bcontrol_in),
      .done_out     (done_out)
   );

   always #5 clk_in = ~clk_in;

   logic [UNITS-1:0] ctrl_m [LAYERS];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < int'(LAYERS); i++) begin
         cfg_layer_in = LW'(i);
         #1;
         chk(tag, 32'(cfg_data_out), 32'(ctrl_m[i]));
      end
      @(negedge clk_in);
   endtask

   task automatic cfg_write(input int l, input logic [UNITS-1:0] d);
      cfg_we_in    = 1'b1;
      cfg_layer_in = LW'(l);
      cfg_data_in  = d;
      ctrl_m[l]    = d;
      @(negedge clk_in);
      cfg_we_in    = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ready"}, 32'(ready_out), 32'd1);
      chk({tag, "_step"},  32'(step_out),  32'd0);
      chk({tag, "_done"},  32'(done_out),  32'd0);
      chk({tag, "_layer"}, 32'(layer_out), 32'd0);
      chk({tag, "_fctl"},  32'(fcontrol_out), 32'd0);
   endtask

   // One complete run as seen from the bank: LAYERS forward steps, LAYERS backward
   // steps when training, then a done cycle. abort_k selects the aborting step (-1 none).
   task automatic run(input bit train, input int abort_k, input bit bc_rand,
                      input logic [UNITS-1:0] bc_const, input bit stray);
      int n;
      logic [UNITS-1:0] bc;
      n = train ? 2 * int'(LAYERS) : int'(LAYERS);
      start_in = 1'b1;
      train_in = train;
      abort_in = stray ? 1'($urandom) : 1'b0;
      if (stray && ($urandom_range(0, 1) == 1)) begin
         cfg_we_in    = 1'b1;
         cfg_layer_in = LW'($urandom_range(0, LAYERS - 1));
         cfg_data_in  = UNITS'($urandom);
         ctrl_m[cfg_layer_in] = cfg_data_in;
      end
      @(negedge clk_in);
      start_in  = 1'b0;
      cfg_we_in = 1'b0;
      abort_in  = 1'b0;
      train_in  = 1'($urandom);
      for (int k = 0; k < n; k++) begin
         int lay;
         bit bwd;
         bwd = (k >= int'(LAYERS));
         lay = bwd ? (2 * int'(LAYERS) - 1 - k) : k;
         chk("step",  32'(step_out),     32'd1);
         chk("dir",   32'(dir_out),      32'(bwd));
         chk("layer", 32'(layer_out),    32'(lay));
         chk("fctl",  32'(fcontrol_out), 32'(ctrl_m[lay]));
         chk("ready", 32'(ready_out),    32'd0);
         chk("done",  32'(done_out),     32'd0);
         bc = bc_rand ? UNITS'($urandom) : bc_const;
         bcontrol_in = bc;
         if (stray) begin
            start_in     = 1'($urandom);
            cfg_we_in    = 1'($urandom);
            cfg_layer_in = LW'($urandom_range(0, LAYERS - 1));
            cfg_data_in  = UNITS'($urandom);
         end
         abort_in = (k == abort_k);
         if (bwd) ctrl_m[lay] = bc;
         @(negedge clk_in);
         start_in  = 1'b0;
         cfg_we_in = 1'b0;
         if (k == abort_k) begin
            abort_in = 1'b0;
            check_idle("abort");
            return;
         end
      end
      chk("done_pulse", 32'(done_out),     32'd1);
      chk("done_step",  32'(step_out),     32'd0);
      chk("done_ready", 32'(ready_out),    32'd0);
      chk("done_fctl",  32'(fcontrol_out), 32'd0);
      if (stray) begin
         start_in     = 1'($urandom);
         cfg_we_in    = 1'($urandom);
         cfg_layer_in = LW'($urandom_range(0, LAYERS - 1));
         cfg_data_in  = UNITS'($urandom);
      end
      @(negedge clk_in);
      start_in  = 1'b0;
      cfg_we_in = 1'b0;
      check_idle("post_done");
   endtask

   initial begin
      for (int i = 0; i < int'(LAYERS); i++) ctrl_m[i] = '0;

      #12;
      check_idle("rst");
      chk("rst_dir", 32'(dir_out), 32'd0);
      @(negedge clk_in);
      rst_n = 1'b1;
      read_all("rst_ctrl");

      cfg_write(0, 8'h11);
      cfg_write(1, 8'h22);
      cfg_write(2, 8'h44);
      cfg_write(3, 8'h88);
      read_all("cfg_rd");
      run(1'b0, -1, 1'b0, 8'h00, 1'b0);
      read_all("infer_ctrl");

      run(1'b1, -1, 1'b0, 8'hA5, 1'b0);
      read_all("train_ctrl");

      cfg_write(0, 8'h11);
      cfg_write(1, 8'h22);
      cfg_write(2, 8'h44);
      cfg_write(3, 8'h88);
      run(1'b1, int'(LAYERS) + 1, 1'b0, 8'hFF, 1'b0);
      read_all("abort_ctrl");

      abort_in = 1'b1;
      @(negedge clk_in);
      abort_in = 1'b0;
      check_idle("idle_abort");

      run(1'b0, -1, 1'b0, 8'h00, 1'b1);
      read_all("stray_ctrl");

      for (int r = 0; r < 40; r++) begin
         bit tr;
         int ak;
         tr = 1'($urandom);
         ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * LAYERS - 1)) : -1;
         if ($urandom_range(0, 1) == 1)
            cfg_write(int'($urandom_range(0, LAYERS - 1)), UNITS'($urandom));
         run(tr, ak, 1'b1, 8'h00, 1'b1);
         read_all("rand_ctrl");
      end

      start_in = 1'b1;
      train_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      @(negedge clk_in);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_rst");
      chk("async_rst_dir", 32'(dir_out), 32'd0);
      for (int i = 0; i < int'(LAYERS); i++) ctrl_m[i] = '0;
      read_all("async_rst_ctrl");
      rst_n = 1'b1;
      @(negedge clk_in);
      check_idle("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
